// File: rtl/rgb_led_scheduler_if.sv
// Requester-to-scheduler bundle for the shared RGB LED: two req/colour/ack
// channels plus the scheduler status and the active-low LED pin outputs.
interface rgb_led_scheduler_if;
   logic       i_req_a;
   logic [2:0] i_color_a;
   logic       o_ack_a;
   logic       i_req_b;
   logic [2:0] i_color_b;
   logic       o_ack_b;
   logic       o_busy;
   logic       o_owner;
   logic       o_led_r;
   logic       o_led_g;
   logic       o_led_b;

   modport master (
      output i_req_a, i_color_a, i_req_b, i_color_b,
      input  o_ack_a, o_ack_b, o_busy, o_owner, o_led_r, o_led_g, o_led_b
   );

   modport slave (
      input  i_req_a, i_color_a, i_req_b, i_color_b,
      output o_ack_a, o_ack_b, o_busy, o_owner, o_led_r, o_led_g, o_led_b
   );
endinterface

// File: rtl/rgb_led_scheduler.sv
// Round-robin owner of the single active-low RGB LED: grant 1 edge after req, lit HOLD, dark GAP.
// Requests are held by the requester until ack; requests seen outside IDLE are simply not served yet.
module rgb_led_scheduler #(
   parameter int HOLD_CYCLES = 12000000,
   parameter int GAP_CYCLES  = 1200000,
   parameter int CNT_W       = 24
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   rgb_led_scheduler_if.slave   bus
);
   localparam int              HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_served;
   logic [2:0]       led;
   logic             ack_a;
   logic             ack_b;
   logic             busy;
   logic             owner;

   logic             winner;
   logic [2:0]       win_color;

   // On a tie the requester that was not served last wins, so continuous
   // dual requests alternate.
   always_comb begin
      winner    = (bus.i_req_a && bus.i_req_b) ? ~last_served : bus.i_req_b;
      win_color = winner ? bus.i_color_b : bus.i_color_a;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         last_served <= 1'b1;
         led         <= 3'b111;
         ack_a       <= 1'b0;
         ack_b       <= 1'b0;
         busy        <= 1'b0;
         owner       <= 1'b0;
      end else begin
         ack_a <= 1'b0;
         ack_b <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_req_a || bus.i_req_b) begin
                  state       <= HOLD;
                  cnt         <= HOLD_LOAD;
                  led         <= ~win_color;
                  ack_a       <= ~winner;
                  ack_b       <= winner;
                  owner       <= winner;
                  last_served <= winner;
                  busy        <= 1'b1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  led <= 3'b111;
                  if (GAP_CYCLES == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= GAP;
                     cnt   <= GAP_LOAD;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               led   <= 3'b111;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_led_r = led[2];
   assign bus.o_led_g = led[1];
   assign bus.o_led_b = led[0];
   assign bus.o_ack_a = ack_a;
   assign bus.o_ack_b = ack_b;
   assign bus.o_busy  = busy;
   assign bus.o_owner = owner;
endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Bench for rgb_led_scheduler with HOLD=4, GAP=2: directed scenarios plus a
// grant-timeline model compared against the DUT on every falling edge.
module tb_rgb_led_scheduler;
   localparam int H = 4;
   localparam int G = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;

   rgb_led_scheduler_if bus();

   rgb_led_scheduler #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(4)) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   // Model: remember only when the last grant happened and what colour it
   // carried; outputs follow from the elapsed cycle count.
   bit         m_idle  = 1'b1;
   bit         m_last  = 1'b1;
   bit         m_owner = 1'b0;
   bit         m_ack_a = 1'b0;
   bit         m_ack_b = 1'b0;
   int         since   = 0;
   logic [2:0] m_col   = 3'b000;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle = 1'b1; m_last = 1'b1; m_owner = 1'b0;
         m_ack_a = 1'b0; m_ack_b = 1'b0; since = 0; m_col = 3'b000;
      end else begin
         cyc = cyc + 1;
         m_ack_a = 1'b0;
         m_ack_b = 1'b0;
         if (m_idle) begin
            if (bus.i_req_a || bus.i_req_b) begin
               bit w;
               w       = (bus.i_req_a && bus.i_req_b) ? !m_last : bus.i_req_b;
               m_col   = w ? bus.i_color_b : bus.i_color_a;
               m_ack_a = !w;
               m_ack_b = w;
               m_owner = w;
               m_last  = w;
               m_idle  = 1'b0;
               since   = 0;
            end
         end else begin
            since = since + 1;
            if (since >= H + G) m_idle = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [2:0] exp_led;
      exp_led = (!m_idle && since < H) ? ~m_col : 3'b111;
      chk("model_led", {5'd0, bus.o_led_r, bus.o_led_g, bus.o_led_b}, {5'd0, exp_led});
      chk("model_ack_a", {7'd0, bus.o_ack_a}, {7'd0, m_ack_a});
      chk("model_ack_b", {7'd0, bus.o_ack_b}, {7'd0, m_ack_b});
      chk("model_busy", {7'd0, bus.o_busy}, {7'd0, !m_idle});
      chk("model_owner", {7'd0, bus.o_owner}, {7'd0, m_owner});
   end

   function automatic logic [2:0] leds();
      return {bus.o_led_r, bus.o_led_g, bus.o_led_b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.o_busy !== 1'b0 && n < 50) begin
         tick();
         n = n + 1;
      end
      chk("wait_idle_timeout", {7'd0, bus.o_busy}, 8'd0);
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      tick();
      #3 rst_n = 1'b1;
   endtask

   initial begin
      int lit, bsy, nack;
      int ack_who[$];
      int ack_cyc[$];
      bus.i_req_a = 1'b0; bus.i_color_a = 3'b000;
      bus.i_req_b = 1'b0; bus.i_color_b = 3'b000;

      // 1: reset holds everything dark and idle
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_led", {5'd0, leds()}, 8'h07);
         chk("rst_acks", {6'd0, bus.o_ack_a, bus.o_ack_b}, 8'd0);
         chk("rst_busy", {7'd0, bus.o_busy}, 8'd0);
      end
      #3 rst_n = 1'b1;

      // 2: A alone, red
      tick();
      bus.i_req_a = 1'b1; bus.i_color_a = 3'b100;
      tick();
      chk("a_ack", {7'd0, bus.o_ack_a}, 8'd1);
      chk("a_led", {5'd0, leds()}, 8'h03);
      bus.i_req_a = 1'b0;
      lit = 1; bsy = 1; nack = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.o_led_r == 1'b0) lit = lit + 1;
         if (bus.o_busy) bsy = bsy + 1;
         if (bus.o_ack_a) nack = nack + 1;
      end
      chk("a_lit_cycles", 8'(lit), 8'd4);
      chk("a_busy_cycles", 8'(bsy), 8'd6);
      chk("a_extra_acks", 8'(nack), 8'd0);

      // 3: simultaneous, continuously held requests alternate A,B,A,B
      pulse_reset();
      tick();
      bus.i_color_a = 3'b001; bus.i_color_b = 3'b010;
      bus.i_req_a = 1'b1; bus.i_req_b = 1'b1;
      for (int i = 0; i < 60 && ack_who.size() < 4; i++) begin
         tick();
         if (bus.o_ack_a) begin
            ack_who.push_back(0); ack_cyc.push_back(cyc);
            chk("tie_led_a", {5'd0, leds()}, 8'h06);
         end
         if (bus.o_ack_b) begin
            ack_who.push_back(1); ack_cyc.push_back(cyc);
            chk("tie_led_b", {5'd0, leds()}, 8'h05);
         end
      end
      bus.i_req_a = 1'b0; bus.i_req_b = 1'b0;
      chk("tie_ack_count", 8'(ack_who.size()), 8'd4);
      for (int i = 0; i < ack_who.size(); i++) begin
         chk("tie_order", 8'(ack_who[i]), 8'(i % 2));
         if (i > 0) chk("tie_spacing", 8'(ack_cyc[i] - ack_cyc[i-1]), 8'd7);
      end

      // 4: B asks during A's hold, served once the scheduler is idle again
      wait_idle();
      tick();
      bus.i_req_a = 1'b1; bus.i_color_a = 3'b100;
      tick();
      chk("b4_ack_a", {7'd0, bus.o_ack_a}, 8'd1);
      bus.i_req_a = 1'b0;
      bus.i_req_b = 1'b1; bus.i_color_b = 3'b011;
      for (int i = 0; i < 6; i++) tick();
      chk("b4_no_early_ack", {7'd0, bus.o_ack_b}, 8'd0);
      tick();
      chk("b4_ack_b", {7'd0, bus.o_ack_b}, 8'd1);
      chk("b4_led", {5'd0, leds()}, 8'h04);
      chk("b4_owner", {7'd0, bus.o_owner}, 8'd1);
      bus.i_req_b = 1'b0;

      // 5: request withdrawn during a hold is never granted
      wait_idle();
      tick();
      bus.i_req_a = 1'b1; bus.i_color_a = 3'b010;
      tick();
      bus.i_req_a = 1'b0;
      tick();
      bus.i_req_b = 1'b1; bus.i_color_b = 3'b001;
      tick();
      tick();
      bus.i_req_b = 1'b0;
      nack = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.o_ack_a || bus.o_ack_b) nack = nack + 1;
      end
      chk("wd_no_ack", 8'(nack), 8'd0);
      chk("wd_busy", {7'd0, bus.o_busy}, 8'd0);
      chk("wd_led", {5'd0, leds()}, 8'h07);

      // 6: reset mid-hold darkens at once and restores A's tie priority
      tick();
      bus.i_req_a = 1'b1; bus.i_color_a = 3'b111;
      tick();
      bus.i_req_a = 1'b0;
      tick();
      chk("r6_lit", {5'd0, leds()}, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      chk("r6_async_led", {5'd0, leds()}, 8'h07);
      chk("r6_async_busy", {7'd0, bus.o_busy}, 8'd0);
      tick();
      #3 rst_n = 1'b1;
      tick();
      bus.i_req_a = 1'b1; bus.i_req_b = 1'b1;
      bus.i_color_a = 3'b110; bus.i_color_b = 3'b011;
      tick();
      chk("r6_tie_a", {6'd0, bus.o_ack_a, bus.o_ack_b}, 8'd2);
      chk("r6_tie_led", {5'd0, leds()}, 8'h01);
      bus.i_req_a = 1'b0; bus.i_req_b = 1'b0;
      wait_idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
